piece_move_ctrl: RTL and testbench
==================================

// Module: piece_move_ctrl
// PURPOSE
//  Active-piece movement sequencer; sits directly upstream of checkLeft/checkRight/checkDown.
//  Turns player requests and the gravity tick into one-at-a-time collision queries.
//  Drives the checkers' Enable and owns the piece origin XPOS/YPOS.
//  Commits a move only on canMove; a failed gravity/soft-drop check issues a lock pulse to the board-write stage.
// PARAMETERS
//  SPAWN_X  6   XPOS loaded on spawn
//  SPAWN_Y  0   YPOS loaded on spawn
//  X_MIN    0   XPOS never decremented below this
//  X_MAX    12  XPOS never incremented at/above this
//  Y_MAX    16  YPOS never incremented at/above this
// PORTS
//  Clock         in   1  system clock, all state on posedge
//  Reset         in   1  asynchronous, active-high
//  spawn         in   1  1-cycle pulse: new piece present, load origin
//  btnLeft       in   1  level, player left; internally rising-edge detected
//  btnRight      in   1  level, player right; internally rising-edge detected
//  btnDown       in   1  level, soft drop; internally rising-edge detected
//  gravityTick   in   1  1-cycle pulse from the drop timer
//  canMoveLeft   in   1  registered result of checkLeft
//  canMoveRight  in   1  registered result of checkRight
//  canMoveDown   in   1  registered result of checkDown
//  leftEnable    out  1  Enable to checkLeft
//  rightEnable   out  1  Enable to checkRight
//  downEnable    out  1  Enable to checkDown
//  XPOS          out  4  piece origin column
//  YPOS          out  5  piece origin row
//  lockPiece     out  1  1-cycle pulse: piece cannot fall, write to board
//  busy          out  1  high in CHECK/EVAL/LOCK
// BEHAVIOUR
//  Reset: state=IDLE; XPOS=SPAWN_X, YPOS=SPAWN_Y; all enables, lockPiece and busy=0.
//  Reset also clears the pending flags and the edge-detect history regs.
//  Reset mid-query abandons the query; no position update.
//  Edge detect: reqL = btnLeft & ~btnLeft_q (same for R, D); history regs update every cycle.
//  Pending flags pendG/pendD/pendL/pendR:
//    set by gravityTick/reqD/reqL/reqR in any state except IDLE;
//    cleared when their query starts; a repeat while pending is absorbed (no queueing).
//  FSM states:
//   IDLE: wait for spawn. spawn -> load SPAWN_X/SPAWN_Y, clear pending, -> READY.
//   READY: select highest-priority pending request: G > D > L > R.
//     - G and D map to the same down query.
//     - none pending -> stay.
//   CHECK: exactly one enable high for exactly this one cycle; target latched in `op`.
//     The checker registers canMove on the edge leaving CHECK. -> EVAL.
//   EVAL: all enables low; sample canMove* for `op`.
//     - L: canMoveLeft & XPOS>X_MIN -> XPOS-1.
//     - R: canMoveRight & XPOS<X_MAX-1 -> XPOS+1.
//     - D: canMoveDown & YPOS<Y_MAX-1 -> YPOS+1.
//     Success or failed L/R -> READY. Failed D (either cause) -> LOCK.
//   LOCK: lockPiece=1 for this one cycle; clear all pending -> IDLE.
//  Latency: request seen in READY -> enable next cycle -> XPOS/YPOS updated 2 cycles after the enable cycle.
//  Arithmetic: unsigned, no wrap. Bound guards make 0-1 and 15+1 impossible.
//  Simultaneous events:
//    spawn outside IDLE is ignored.
//    gravityTick and a button in the same cycle both set pending; G is served first.
//    A request that arrives during CHECK/EVAL is served after return to READY.
//  Outputs are registered; XPOS/YPOS hold their value in all states except an EVAL success or a spawn load.
// TESTING
//  T1 reset: assert Reset mid-EVAL -> XPOS=6, YPOS=0, state IDLE, all outputs 0 immediately (async).
//  T2 spawn, btnLeft rise, canMoveLeft=1:
//     -> leftEnable exactly 1 cycle; XPOS 6->5 two cycles later; busy falls.
//  T3 XPOS=11, btnRight, canMoveRight=1 -> no increment (X_MAX guard), state READY.
//     XPOS=0, btnLeft -> stays 0.
//  T4 gravityTick+btnRight same cycle, both canMove=1:
//     -> downEnable first, YPOS+1; then rightEnable, XPOS+1; 6-cycle total.
//  T5 gravityTick, canMoveDown=0:
//     -> lockPiece single pulse in LOCK, then IDLE.
//     -> btnLeft afterwards makes no enable until the next spawn.
//  T6 hold btnLeft high 20 cycles -> only one query.
//     gravityTick twice during one query -> only one extra down query.

Source files
------------

// File: rtl/piece_move_ctrl.sv
// Active-piece movement sequencer. It turns player button edges and gravity
// ticks into one-at-a-time collision queries, owns the piece origin, and
// raises a lock pulse when the piece can no longer fall.
module piece_move_ctrl #(
    parameter int unsigned SPAWN_X = 6,
    parameter int unsigned SPAWN_Y = 0,
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = 12,
    parameter int unsigned Y_MAX   = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       spawn,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnDown,
    input  logic       gravityTick,
    input  logic       canMoveLeft,
    input  logic       canMoveRight,
    input  logic       canMoveDown,
    output logic       leftEnable,
    output logic       rightEnable,
    output logic       downEnable,
    output logic [3:0] XPOS,
    output logic [4:0] YPOS,
    output logic       lockPiece,
    output logic       busy
);

    localparam logic [3:0] SPAWN_X_C = 4'(SPAWN_X);
    localparam logic [4:0] SPAWN_Y_C = 5'(SPAWN_Y);
    localparam logic [3:0] X_MIN_C   = 4'(X_MIN);
    localparam logic [3:0] X_LAST_C  = 4'(X_MAX - 1);
    localparam logic [4:0] Y_LAST_C  = 5'(Y_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_CHECK,
        S_EVAL,
        S_LOCK
    } state_t;

    typedef enum logic [1:0] {
        OP_L,
        OP_R,
        OP_D
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [3:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic       pend_g_q, pend_g_d;
    logic       pend_d_q, pend_d_d;
    logic       pend_l_q, pend_l_d;
    logic       pend_r_q, pend_r_d;
    logic       btn_l_q, btn_r_q, btn_d_q;
    logic       len_q, len_d;
    logic       ren_q, ren_d;
    logic       den_q, den_d;
    logic       lock_q, lock_d;
    logic       busy_q, busy_d;

    logic       req_l, req_r, req_d;
    logic       accept;
    logic       clr_g, clr_d, clr_l, clr_r;

    assign req_l  = btnLeft  & ~btn_l_q;
    assign req_r  = btnRight & ~btn_r_q;
    assign req_d  = btnDown  & ~btn_d_q;
    assign accept = (state_q != S_IDLE);

    // State, position, pending flags, edge history and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_L;
            x_q      <= SPAWN_X_C;
            y_q      <= SPAWN_Y_C;
            pend_g_q <= 1'b0;
            pend_d_q <= 1'b0;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            btn_l_q  <= 1'b0;
            btn_r_q  <= 1'b0;
            btn_d_q  <= 1'b0;
            len_q    <= 1'b0;
            ren_q    <= 1'b0;
            den_q    <= 1'b0;
            lock_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pend_g_q <= pend_g_d;
            pend_d_q <= pend_d_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            btn_l_q  <= btnLeft;
            btn_r_q  <= btnRight;
            btn_d_q  <= btnDown;
            len_q    <= len_d;
            ren_q    <= ren_d;
            den_q    <= den_d;
            lock_q   <= lock_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, request arbitration, move commit and next output values
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        clr_g   = 1'b0;
        clr_d   = 1'b0;
        clr_l   = 1'b0;
        clr_r   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (spawn) begin
                    x_d     = SPAWN_X_C;
                    y_d     = SPAWN_Y_C;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                // Gravity and soft drop share one down query, which satisfies both
                if (pend_g_q || pend_d_q) begin
                    op_d    = OP_D;
                    clr_g   = 1'b1;
                    clr_d   = 1'b1;
                    state_d = S_CHECK;
                end else if (pend_l_q) begin
                    op_d    = OP_L;
                    clr_l   = 1'b1;
                    state_d = S_CHECK;
                end else if (pend_r_q) begin
                    op_d    = OP_R;
                    clr_r   = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_READY;
                case (op_q)
                    OP_L: if (canMoveLeft && (x_q > X_MIN_C)) x_d = x_q - 4'd1;
                    OP_R: if (canMoveRight && (x_q < X_LAST_C)) x_d = x_q + 4'd1;
                    OP_D: begin
                        if (canMoveDown && (y_q < Y_LAST_C)) y_d = y_q + 5'd1;
                        else state_d = S_LOCK;
                    end
                    default: state_d = S_READY;
                endcase
            end
            S_LOCK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A fresh edge in the same cycle its flag is consumed is kept as a new request
        pend_g_d = (pend_g_q & ~clr_g) | (accept & gravityTick);
        pend_d_d = (pend_d_q & ~clr_d) | (accept & req_d);
        pend_l_d = (pend_l_q & ~clr_l) | (accept & req_l);
        pend_r_d = (pend_r_q & ~clr_r) | (accept & req_r);
        if ((state_q == S_LOCK) || ((state_q == S_IDLE) && spawn)) begin
            pend_g_d = 1'b0;
            pend_d_d = 1'b0;
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
        end

        len_d  = (state_d == S_CHECK) && (op_d == OP_L);
        ren_d  = (state_d == S_CHECK) && (op_d == OP_R);
        den_d  = (state_d == S_CHECK) && (op_d == OP_D);
        lock_d = (state_d == S_LOCK);
        busy_d = (state_d == S_CHECK) || (state_d == S_EVAL) || (state_d == S_LOCK);
    end

    assign leftEnable  = len_q;
    assign rightEnable = ren_q;
    assign downEnable  = den_q;
    assign XPOS        = x_q;
    assign YPOS        = y_q;
    assign lockPiece   = lock_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for the piece movement sequencer.
module tb_piece_move_ctrl;

    logic       Clock;
    logic       Reset;
    logic       spawn;
    logic       btnLeft, btnRight, btnDown;
    logic       gravityTick;
    logic       canMoveLeft, canMoveRight, canMoveDown;
    logic       leftEnable, rightEnable, downEnable;
    logic [3:0] XPOS;
    logic [4:0] YPOS;
    logic       lockPiece;
    logic       busy;

    int total;
    int bad;

    piece_move_ctrl #(
        .SPAWN_X(6),
        .SPAWN_Y(0),
        .X_MIN  (0),
        .X_MAX  (12),
        .Y_MAX  (16)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .spawn       (spawn),
        .btnLeft     (btnLeft),
        .btnRight    (btnRight),
        .btnDown     (btnDown),
        .gravityTick (gravityTick),
        .canMoveLeft (canMoveLeft),
        .canMoveRight(canMoveRight),
        .canMoveDown (canMoveDown),
        .leftEnable  (leftEnable),
        .rightEnable (rightEnable),
        .downEnable  (downEnable),
        .XPOS        (XPOS),
        .YPOS        (YPOS),
        .lockPiece   (lockPiece),
        .busy        (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_spawn();
        spawn = 1'b1;
        tick();
        spawn = 1'b0;
    endtask

    // One button press followed by a full query: pending, CHECK, EVAL, back to READY
    task automatic move(input int dir);
        if (dir == 0) btnLeft = 1'b1;
        else if (dir == 1) btnRight = 1'b1;
        else gravityTick = 1'b1;
        tick();
        btnLeft = 1'b0; btnRight = 1'b0; gravityTick = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #3;
        total++;
        if ({XPOS, YPOS} !== {4'd6, 5'd0}) begin
            bad++; $display("FAIL reset_pos got x=%0d y=%0d want x=6 y=0", XPOS, YPOS);
        end
        total++;
        if ({leftEnable, rightEnable, downEnable, lockPiece, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_outs got=%b want=00000",
                            {leftEnable, rightEnable, downEnable, lockPiece, busy});
        end
        tick();
        Reset = 1'b0;
        tick();
        btnLeft = 1'b1;
        tick();
        btnLeft = 1'b0;
        tick();
        tick();
        total++;
        if ({leftEnable, busy} !== 2'b00) begin
            bad++; $display("FAIL idle_ignores_btn got=%b want=00", {leftEnable, busy});
        end
    endtask

    task automatic test_left_move();
        do_spawn();
        total++;
        if (XPOS !== 4'd6) begin bad++; $display("FAIL spawn_x got=%0d want=6", XPOS); end
        canMoveLeft = 1'b1;
        btnLeft = 1'b1;
        tick();
        total++;
        if (leftEnable !== 1'b0) begin bad++; $display("FAIL t2_pend_en got=%b want=0", leftEnable); end
        tick();
        total++;
        if ({leftEnable, rightEnable, downEnable, busy} !== 4'b1001) begin
            bad++; $display("FAIL t2_check got=%b want=1001", {leftEnable, rightEnable, downEnable, busy});
        end
        tick();
        total++;
        if ({leftEnable, busy, XPOS} !== {1'b0, 1'b1, 4'd6}) begin
            bad++; $display("FAIL t2_eval got en=%b busy=%b x=%0d want en=0 busy=1 x=6", leftEnable, busy, XPOS);
        end
        tick();
        total++;
        if ({busy, XPOS} !== {1'b0, 4'd5}) begin
            bad++; $display("FAIL t2_commit got busy=%b x=%0d want busy=0 x=5", busy, XPOS);
        end
        btnLeft = 1'b0;
        tick();
    endtask

    task automatic test_x_bounds();
        canMoveRight = 1'b1;
        canMoveLeft  = 1'b1;
        for (int i = 0; i < 6; i++) move(1);
        total++;
        if (XPOS !== 4'd11) begin bad++; $display("FAIL t3_reach11 got=%0d want=11", XPOS); end
        move(1);
        total++;
        if ({XPOS, busy} !== {4'd11, 1'b0}) begin
            bad++; $display("FAIL t3_xmax got x=%0d busy=%b want x=11 busy=0", XPOS, busy);
        end
        canMoveLeft = 1'b0;
        move(0);
        total++;
        if (XPOS !== 4'd11) begin bad++; $display("FAIL t3_blocked got=%0d want=11", XPOS); end
        canMoveLeft = 1'b1;
        for (int i = 0; i < 11; i++) move(0);
        total++;
        if (XPOS !== 4'd0) begin bad++; $display("FAIL t3_reach0 got=%0d want=0", XPOS); end
        move(0);
        total++;
        if ({XPOS, busy} !== {4'd0, 1'b0}) begin
            bad++; $display("FAIL t3_xmin got x=%0d busy=%b want x=0 busy=0", XPOS, busy);
        end
    endtask

    task automatic test_simultaneous();
        canMoveDown  = 1'b1;
        canMoveRight = 1'b1;
        gravityTick  = 1'b1;
        btnRight     = 1'b1;
        tick();
        gravityTick = 1'b0;
        btnRight    = 1'b0;
        tick();
        total++;
        if ({leftEnable, rightEnable, downEnable} !== 3'b001) begin
            bad++; $display("FAIL t4_down_first got=%b want=001", {leftEnable, rightEnable, downEnable});
        end
        tick();
        tick();
        total++;
        if ({XPOS, YPOS} !== {4'd0, 5'd1}) begin
            bad++; $display("FAIL t4_y_commit got x=%0d y=%0d want x=0 y=1", XPOS, YPOS);
        end
        tick();
        total++;
        if ({leftEnable, rightEnable, downEnable} !== 3'b010) begin
            bad++; $display("FAIL t4_right_second got=%b want=010", {leftEnable, rightEnable, downEnable});
        end
        tick();
        tick();
        total++;
        if ({XPOS, YPOS, busy} !== {4'd1, 5'd1, 1'b0}) begin
            bad++; $display("FAIL t4_x_commit got x=%0d y=%0d busy=%b want x=1 y=1 busy=0", XPOS, YPOS, busy);
        end
    endtask

    task automatic test_absorb();
        int nl, nr, nd;
        canMoveLeft = 1'b1;
        nl = 0;
        btnLeft = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (leftEnable) nl++;
        end
        btnLeft = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (leftEnable) nl++;
        end
        total++;
        if (nl !== 1) begin bad++; $display("FAIL t6_held_btn got=%0d want=1 queries", nl); end
        total++;
        if (XPOS !== 4'd0) begin bad++; $display("FAIL t6_held_x got=%0d want=0", XPOS); end

        btnRight = 1'b1;
        tick();
        btnRight = 1'b0;
        tick();
        total++;
        if (rightEnable !== 1'b1) begin bad++; $display("FAIL t6_rcheck got=%b want=1", rightEnable); end
        nr = 0; nd = 0;
        gravityTick = 1'b1;
        tick();
        tick();
        gravityTick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rightEnable) nr++;
            if (downEnable) nd++;
            tick();
        end
        total++;
        if ({nr, nd} !== {32'd0, 32'd1}) begin
            bad++; $display("FAIL t6_grav_absorb got r=%0d d=%0d want r=0 d=1", nr, nd);
        end
        total++;
        if ({XPOS, YPOS} !== {4'd1, 5'd2}) begin
            bad++; $display("FAIL t6_pos got x=%0d y=%0d want x=1 y=2", XPOS, YPOS);
        end
    endtask

    task automatic test_lock();
        int ne;
        canMoveDown = 1'b0;
        gravityTick = 1'b1;
        tick();
        gravityTick = 1'b0;
        tick();
        total++;
        if (downEnable !== 1'b1) begin bad++; $display("FAIL t5_dcheck got=%b want=1", downEnable); end
        tick();
        total++;
        if (lockPiece !== 1'b0) begin bad++; $display("FAIL t5_early_lock got=%b want=0", lockPiece); end
        tick();
        total++;
        if ({lockPiece, busy, YPOS} !== {1'b1, 1'b1, 5'd2}) begin
            bad++; $display("FAIL t5_lock got lock=%b busy=%b y=%0d want lock=1 busy=1 y=2", lockPiece, busy, YPOS);
        end
        tick();
        total++;
        if ({lockPiece, busy} !== 2'b00) begin
            bad++; $display("FAIL t5_lock_pulse got lock=%b busy=%b want 00", lockPiece, busy);
        end
        ne = 0;
        btnLeft = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (leftEnable | rightEnable | downEnable) ne++;
            btnLeft = 1'b0;
        end
        total++;
        if (ne !== 0) begin bad++; $display("FAIL t5_idle_no_en got=%0d want=0", ne); end
    endtask

    task automatic test_y_bound();
        do_spawn();
        total++;
        if ({XPOS, YPOS} !== {4'd6, 5'd0}) begin
            bad++; $display("FAIL respawn got x=%0d y=%0d want x=6 y=0", XPOS, YPOS);
        end
        canMoveDown = 1'b1;
        for (int i = 0; i < 15; i++) move(2);
        total++;
        if (YPOS !== 5'd15) begin bad++; $display("FAIL ymax_reach got=%0d want=15", YPOS); end
        move(2);
        total++;
        if ({lockPiece, YPOS} !== {1'b1, 5'd15}) begin
            bad++; $display("FAIL ymax_lock got lock=%b y=%0d want lock=1 y=15", lockPiece, YPOS);
        end
        tick();
    endtask

    task automatic test_reset_mid_eval();
        do_spawn();
        canMoveRight = 1'b1;
        move(1);
        total++;
        if (XPOS !== 4'd7) begin bad++; $display("FAIL t1_pre got=%0d want=7", XPOS); end
        btnRight = 1'b1;
        tick();
        btnRight = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        total++;
        if ({XPOS, YPOS, leftEnable, rightEnable, downEnable, lockPiece, busy} !== {4'd6, 5'd0, 5'b0}) begin
            bad++; $display("FAIL t1_async got x=%0d y=%0d outs=%b want x=6 y=0 outs=00000",
                            XPOS, YPOS, {leftEnable, rightEnable, downEnable, lockPiece, busy});
        end
        tick();
        Reset = 1'b0;
        tick();
        tick();
        total++;
        if ({XPOS, rightEnable, busy} !== {4'd6, 2'b00}) begin
            bad++; $display("FAIL t1_after got x=%0d ren=%b busy=%b want x=6 ren=0 busy=0", XPOS, rightEnable, busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        spawn = 1'b0;
        btnLeft = 1'b0; btnRight = 1'b0; btnDown = 1'b0;
        gravityTick = 1'b0;
        canMoveLeft = 1'b0; canMoveRight = 1'b0; canMoveDown = 1'b0;

        test_reset();
        test_left_move();
        test_x_bounds();
        test_simultaneous();
        test_absorb();
        test_lock();
        test_y_bound();
        test_reset_mid_eval();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
